// File: rtl/sha256_pkg.sv
// Shared SHA-256 padder types, constants and word helpers.
// Holds the padder FSM state enum, block geometry and pad-bit masking.
package sha256_pkg;

  localparam int          SHA_BLK_WORDS = 16;
  localparam logic [31:0] SHA_PAD_WORD  = 32'h8000_0000;

  typedef enum logic [2:0] {
    IDLE,
    DATA,
    PAD,
    ZERO,
    LEN_HI,
    LEN_LO
  } pad_state_t;

  function automatic logic [31:0] byte_swap32(
    input logic [31:0] w
  );
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  // Keep the r message bits at the top of the word,
  // drop the rest and insert the trailing '1' bit.
  function automatic logic [31:0] pad_mask(
    input logic [31:0] w,
    input logic [4:0]  r
  );
    return (w & ~(32'hFFFF_FFFF >> r)) | (SHA_PAD_WORD >> r);
  endfunction

endpackage

// File: rtl/sha256_msg_padder_if.sv
// Word stream from the padder to the SHA-256 core.
// master: padder drives word/idx/vld/last; slave: core drives rdy.
interface sha256_msg_padder_if;

  logic [31:0] word;
  logic [3:0]  word_idx;
  logic        word_vld;
  logic        word_rdy;
  logic        blk_last;

  modport master (
    output word,
    output word_idx,
    output word_vld,
    output blk_last,
    input  word_rdy
  );

  modport slave (
    input  word,
    input  word_idx,
    input  word_vld,
    input  blk_last,
    output word_rdy
  );

endinterface

// File: rtl/sha256_msg_padder.sv
// SHA-256 message padder: FWFT FIFO words in, padded 16-word blocks out.
// Ports: clk_i/rst_i (sync, active-high), enable_i, start_i, bit_len_i,
//   fifo_empty_i/fifo_rd_dat_i/fifo_rd_en_o (FWFT read side),
//   wp (word stream master), busy_o, done_o.
module sha256_msg_padder
  import sha256_pkg::*;
#(
  parameter bit BYTE_SWAP = 1'b1,
  parameter int LEN_W     = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             enable_i,
  input  logic             start_i,
  input  logic [LEN_W-1:0] bit_len_i,
  input  logic             fifo_empty_i,
  input  logic [31:0]      fifo_rd_dat_i,
  output logic             fifo_rd_en_o,
  sha256_msg_padder_if.master wp,
  output logic             busy_o,
  output logic             done_o
);

  localparam int CW = LEN_W - 5;
  localparam logic [3:0] IDX_ZERO_END =
    4'(SHA_BLK_WORDS - 3);

  pad_state_t state_q;
  pad_state_t state_d;

  logic [LEN_W-1:0] len_q;
  logic [CW-1:0]    cnt_q;
  logic [3:0]       widx_q;
  logic [31:0]      word_q;
  logic [3:0]       idx_q;
  logic             vld_q;
  logic             last_q;
  logic             done_q;

  logic             load;
  logic             at_end;
  logic             n_zero;
  logic [CW-1:0]    cnt_init;
  logic [31:0]      fifo_w;
  logic [31:0]      len_word;
  logic             pop;
  logic             emit;
  logic [31:0]      emit_word;
  logic             emit_last;
  logic             fin;
  logic             start_ok;

  assign load   = !vld_q || wp.word_rdy;
  // The word about to be emitted sits at idx 13,
  // so the length field follows directly.
  assign at_end = (widx_q == IDX_ZERO_END);
  assign n_zero = (bit_len_i == '0);

  // cnt holds "data words left after the current one",
  // so N-1 fits in LEN_W-5 bits even for the largest length.
  assign cnt_init = (bit_len_i[4:0] != 5'd0)
                  ? bit_len_i[LEN_W-1:5]
                  : bit_len_i[LEN_W-1:5] - CW'(1);

  assign fifo_w = BYTE_SWAP ? byte_swap32(fifo_rd_dat_i)
                            : fifo_rd_dat_i;

  assign len_word = 32'(len_q);

  always_comb begin
    state_d   = state_q;
    pop       = 1'b0;
    emit      = 1'b0;
    emit_word = '0;
    emit_last = 1'b0;
    fin       = 1'b0;
    start_ok  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          start_ok = 1'b1;
          state_d  = n_zero ? PAD : DATA;
        end
      end
      DATA: begin
        if (load && !fifo_empty_i) begin
          pop       = 1'b1;
          emit      = 1'b1;
          emit_word = fifo_w;
          if (cnt_q == '0) begin
            if (len_q[4:0] != 5'd0) begin
              emit_word = pad_mask(fifo_w, len_q[4:0]);
              state_d   = at_end ? LEN_HI : ZERO;
            end else begin
              state_d = PAD;
            end
          end
        end
      end
      PAD: begin
        if (load) begin
          emit      = 1'b1;
          emit_word = SHA_PAD_WORD;
          state_d   = at_end ? LEN_HI : ZERO;
        end
      end
      ZERO: begin
        if (load) begin
          emit    = 1'b1;
          state_d = at_end ? LEN_HI : ZERO;
        end
      end
      LEN_HI: begin
        if (load) begin
          emit    = 1'b1;
          state_d = LEN_LO;
        end
      end
      LEN_LO: begin
        // vld && last means the length word is already out
        if (vld_q && last_q) begin
          if (wp.word_rdy) begin
            fin     = 1'b1;
            state_d = IDLE;
          end
        end else if (load) begin
          emit      = 1'b1;
          emit_word = len_word;
          emit_last = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (!enable_i) begin
      state_d  = IDLE;
      pop      = 1'b0;
      emit     = 1'b0;
      fin      = 1'b0;
      start_ok = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      len_q  <= '0;
      cnt_q  <= '0;
      widx_q <= '0;
      word_q <= '0;
      idx_q  <= '0;
      vld_q  <= 1'b0;
      last_q <= 1'b0;
      done_q <= 1'b0;
    end else if (!enable_i) begin
      widx_q <= '0;
      word_q <= '0;
      idx_q  <= '0;
      vld_q  <= 1'b0;
      last_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= fin;
      if (start_ok) begin
        len_q  <= bit_len_i;
        cnt_q  <= cnt_init;
        widx_q <= '0;
      end else if (pop && cnt_q != '0) begin
        cnt_q <= cnt_q - CW'(1);
      end
      if (load) begin
        vld_q  <= emit;
        last_q <= emit_last;
        if (emit) begin
          word_q <= emit_word;
          idx_q  <= widx_q;
          widx_q <= widx_q + 4'd1;
        end
      end
    end
  end

  assign fifo_rd_en_o = pop;
  assign wp.word      = word_q;
  assign wp.word_idx  = idx_q;
  assign wp.word_vld  = vld_q;
  assign wp.blk_last  = last_q;
  assign busy_o       = (state_q != IDLE);
  assign done_o       = done_q;

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Bench for sha256_msg_padder: FWFT FIFO model, core model and
// a scoreboard fed from hand vectors and a padding reference model.
module tb_sha256_msg_padder;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        enable_i;
  logic        start_i;
  logic [31:0] bit_len_i;
  logic        fifo_empty_i;
  logic [31:0] fifo_rd_dat_i;
  logic        fifo_rd_en_o;
  logic        busy_o;
  logic        done_o;

  always #5 clk_i = ~clk_i;

  sha256_msg_padder_if wif();

  sha256_msg_padder #(
    .BYTE_SWAP(1'b1),
    .LEN_W    (32)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .enable_i     (enable_i),
    .start_i      (start_i),
    .bit_len_i    (bit_len_i),
    .fifo_empty_i (fifo_empty_i),
    .fifo_rd_dat_i(fifo_rd_dat_i),
    .fifo_rd_en_o (fifo_rd_en_o),
    .wp           (wif),
    .busy_o       (busy_o),
    .done_o       (done_o)
  );

  typedef struct packed {
    logic [31:0] w;
    logic [3:0]  idx;
    logic        last;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] fifo_q[$];
  int          checks = 0;
  int          errors = 0;
  int          done_cnt = 0;
  int          pop_cnt = 0;
  bit          gap_mode = 1'b0;
  bit          rand_rdy = 1'b0;
  bit          pop_pend = 1'b0;
  bit          stall_pend = 1'b0;
  exp_t        stall_v;
  exp_t        got;
  exp_t        e;

  // FIFO and core drivers change inputs 1 time unit after the edge
  always @(posedge clk_i) begin
    #1;
    if (pop_pend && fifo_q.size() > 0)
      void'(fifo_q.pop_front());
    pop_pend = 1'b0;
    wif.word_rdy = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    fifo_empty_i = (fifo_q.size() == 0) ||
                   (gap_mode && $urandom_range(0, 2) == 0);
    fifo_rd_dat_i = (fifo_q.size() > 0) ? fifo_q[0] : 32'h0;
  end

  // Monitor: everything sampled on the falling edge
  always @(negedge clk_i) begin
    if (!rst_i) begin
      got = {wif.word, wif.word_idx, wif.blk_last};
      if (stall_pend && enable_i) begin
        checks++;
        if (!wif.word_vld || got != stall_v) begin
          errors++;
          $display("FAIL stall_stable: got vld=%b %h/%0d/%b required %h/%0d/%b",
                   wif.word_vld, got.w, got.idx, got.last,
                   stall_v.w, stall_v.idx, stall_v.last);
        end
      end
      if (wif.word_vld && wif.word_rdy) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_word: got %h/%0d/%b",
                   got.w, got.idx, got.last);
        end else begin
          e = exp_q.pop_front();
          if (got != e) begin
            errors++;
            $display("FAIL word: got %h/%0d/%b required %h/%0d/%b",
                     got.w, got.idx, got.last, e.w, e.idx, e.last);
          end
        end
      end
      stall_pend = wif.word_vld && !wif.word_rdy && enable_i;
      stall_v    = got;
      if (fifo_rd_en_o) begin
        checks++;
        pop_cnt++;
        pop_pend = 1'b1;
        if (fifo_empty_i) begin
          errors++;
          $display("FAIL pop_while_empty: got rd_en=1 required 0");
        end
      end
      if (done_o) done_cnt++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] g,
                     input logic [31:0] r);
    checks++;
    if (g !== r) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", nm, g, r);
    end
  endtask

  function automatic logic [31:0] swp(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

  // Reference padding: build the whole padded message, then slice it
  task automatic model(input int bl, input logic [31:0] msg[$]);
    int          nblk;
    int          tot;
    int          pw;
    int          sh;
    logic [31:0] allones;
    logic [31:0] padw;
    logic [31:0] m[];
    nblk    = (bl + 65 + 511) / 512;
    tot     = nblk * 16;
    allones = 32'hFFFF_FFFF;
    padw    = 32'h8000_0000;
    m = new[tot];
    for (int i = 0; i < tot; i++) m[i] = 32'h0;
    for (int j = 0; j < msg.size(); j++) m[j] = msg[j];
    pw = bl / 32;
    sh = bl % 32;
    m[pw] = (m[pw] & ~(allones >> sh)) | (padw >> sh);
    m[tot-1] = bl;
    for (int i = 0; i < tot; i++)
      exp_q.push_back('{w: m[i], idx: 4'(i % 16),
                        last: (i == tot - 1)});
  endtask

  task automatic load_msg(input int bl, input logic [31:0] base,
                          input logic [31:0] step);
    logic [31:0] msg[$];
    logic [31:0] d;
    for (int i = 0; i < (bl + 31) / 32; i++) begin
      d = base + step * i;
      fifo_q.push_back(d);
      msg.push_back(swp(d));
    end
    model(bl, msg);
  endtask

  task automatic start_msg(input int bl);
    bit_len_i = bl;
    start_i   = 1'b1;
    tick(1);
    start_i   = 1'b0;
  endtask

  task automatic go(input string nm, input int bl, input int npops);
    int d0;
    int p0;
    int n;
    d0 = done_cnt;
    p0 = pop_cnt;
    start_msg(bl);
    n = 0;
    while (done_cnt == d0 && n < 3000) begin
      tick(1);
      n++;
    end
    tick(3);
    chk({nm, "_done"}, done_cnt - d0, 1);
    chk({nm, "_pops"}, pop_cnt - p0, npops);
    chk({nm, "_left"}, exp_q.size(), 0);
    chk({nm, "_busy"}, 32'(busy_o), 0);
  endtask

  task automatic hand_abc();
    fifo_q.push_back(32'h0063_6261);
    exp_q.push_back('{w: 32'h6162_6380, idx: 4'd0, last: 1'b0});
    for (int i = 1; i < 15; i++)
      exp_q.push_back('{w: 32'h0, idx: 4'(i), last: 1'b0});
    exp_q.push_back('{w: 32'h0000_0018, idx: 4'd15, last: 1'b1});
  endtask

  initial begin
    int n;
    int d0;
    rst_i         = 1'b1;
    enable_i      = 1'b1;
    start_i       = 1'b0;
    bit_len_i     = 32'h0;
    fifo_empty_i  = 1'b1;
    fifo_rd_dat_i = 32'h0;
    wif.word_rdy  = 1'b0;
    tick(3);
    chk("rst_vld", 32'(wif.word_vld), 0);
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_done", 32'(done_o), 0);
    chk("rst_rden", 32'(fifo_rd_en_o), 0);
    chk("rst_last", 32'(wif.blk_last), 0);
    chk("rst_word", wif.word, 0);
    chk("rst_idx", 32'(wif.word_idx), 0);
    rst_i = 1'b0;
    tick(2);

    hand_abc();
    go("abc", 24, 1);

    exp_q.push_back('{w: 32'h8000_0000, idx: 4'd0, last: 1'b0});
    for (int i = 1; i < 15; i++)
      exp_q.push_back('{w: 32'h0, idx: 4'(i), last: 1'b0});
    exp_q.push_back('{w: 32'h0, idx: 4'd15, last: 1'b1});
    go("len0", 0, 0);

    load_msg(448, 32'h0302_0100, 32'h0404_0404);
    go("len448", 448, 14);

    load_msg(512, 32'hA55A_0F0F, 32'h0101_0103);
    go("len512", 512, 16);

    load_msg(424, 32'h1234_5678, 32'h1111_0001);
    go("pad_idx13", 424, 14);

    load_msg(484, 32'hDEAD_BEEF, 32'h0F0F_1001);
    go("pad_idx15", 484, 16);

    gap_mode = 1'b1;
    rand_rdy = 1'b1;
    load_msg(448, 32'h0302_0100, 32'h0404_0404);
    go("len448_rand", 448, 14);
    gap_mode = 1'b0;
    rand_rdy = 1'b0;
    tick(2);

    load_msg(448, 32'h0302_0100, 32'h0404_0404);
    d0 = done_cnt;
    start_msg(448);
    n = 0;
    while (!(wif.word_vld && wif.word_idx == 4'd4) && n < 200) begin
      tick(1);
      n++;
    end
    chk("abort_reach", 32'(n < 200), 1);
    enable_i = 1'b0;
    tick(1);
    chk("abort_vld", 32'(wif.word_vld), 0);
    chk("abort_busy", 32'(busy_o), 0);
    chk("abort_last", 32'(wif.blk_last), 0);
    tick(4);
    chk("abort_nodone", done_cnt - d0, 0);
    exp_q.delete();
    fifo_q.delete();
    enable_i = 1'b1;
    tick(2);

    hand_abc();
    go("abc_after_abort", 24, 1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

endmodule
